// File: rtl/io_input_ctrl_pkg.sv
// Shared IO definitions for the input side of the CPU IO block.
// Pure declarations and helpers, no state.
// Not applicable: no flow control lives here.
package io_input_ctrl_pkg;

  localparam int DATA_LEN     = 32;
  localparam int REG_ADDR_LEN = 6;
  localparam int CNT_LEN      = 16;

  localparam logic [REG_ADDR_LEN-1:0] IO_SW_ADDR  = 6'b110000;
  localparam logic [REG_ADDR_LEN-1:0] IO_BTN_ADDR = 6'b110001;
  localparam logic [REG_ADDR_LEN-1:0] IO_EVT_ADDR = 6'b110010;

  // Event word layout: press count on top, sticky flags in the low half.
  typedef struct packed {
    logic [CNT_LEN-1:0] count;
    logic [15:0]        flags;
  } evt_word_t;

  // Number of set bits in a 16-bit vector (button vectors are zero-extended).
  function automatic logic [CNT_LEN-1:0] popcount16(input logic [15:0] v);
    logic [CNT_LEN-1:0] sum;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum = sum + CNT_LEN'(v[i]);
    end
    return sum;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One button: 2-flop synchronizer, then a level accepted after DB_CNT_MAX stable cycles.
// Latency: 2 sync edges + DB_CNT_MAX edges from raw change to db.
// No backpressure: free-running sampler.
module io_debounce #(
  parameter int DB_CNT_MAX = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DB_CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT_MAX - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_next;
  logic          db_next;

  // Count consecutive disagreeing samples; flip db on the last one, clear on agreement.
  always_comb begin
    db_next  = db;
    cnt_next = '0;
    if (s2 != db) begin
      if (cnt == CNT_LAST) begin
        db_next = s2;
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

  // A rise is visible in the same cycle the flop will take the new level.
  assign rise = db_next & ~db;

  // Synchronizer, debounced level and counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      db  <= db_next;
      cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/io_input_ctrl.sv
// Board switch/button front end feeding the IO input mux (switch, button, event words).
// Latency: switches 2 edges; buttons 2 + DB_CNT_MAX edges; event word same edge as db rise.
// No backpressure: event flags clear on an event-word load, count only on reset.
module io_input_ctrl
  import io_input_ctrl_pkg::*;
#(
  parameter int SW_WIDTH   = 16,      // must not exceed DATA_LEN
  parameter int BTN_WIDTH  = 5,       // must not exceed 16 (flags share the low half)
  parameter int DB_CNT_MAX = 1000000  // must be at least 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SW_WIDTH-1:0]     sw_raw,
  input  logic [BTN_WIDTH-1:0]    btn_raw,
  input  logic                    rd_en,
  input  logic [REG_ADDR_LEN-1:0] rd_addr,
  output logic [DATA_LEN-1:0]     in0,
  output logic [DATA_LEN-1:0]     in1,
  output logic [DATA_LEN-1:0]     in2
);

  logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
  logic [BTN_WIDTH-1:0] db, rise;
  logic [BTN_WIDTH-1:0] flags, flags_next;
  logic [CNT_LEN-1:0]   count, count_next;
  logic                 clr;
  evt_word_t            evt;

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    io_debounce #(
      .DB_CNT_MAX(DB_CNT_MAX)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (btn_raw[i]),
      .db  (db[i]),
      .rise(rise[i])
    );
  end

  assign clr = rd_en && (rd_addr == IO_EVT_ADDR);

  // Next event state: a rise in the clear cycle keeps its flag; count wraps mod 2^16.
  always_comb begin
    flags_next = (flags & ~{BTN_WIDTH{clr}}) | rise;
    count_next = count + popcount16(16'(rise));
  end

  // Switch synchronizer and event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      flags <= '0;
      count <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s2 <= sw_s1;
      flags <= flags_next;
      count <= count_next;
    end
  end

  // Pack the event word; the mux sees pre-clear flags during the reading cycle.
  always_comb begin
    evt.count = count;
    evt.flags = 16'(flags);
  end

  assign in0 = DATA_LEN'(sw_s2);
  assign in1 = DATA_LEN'(db);
  assign in2 = evt;

endmodule
